// File: rtl/bus_arbiter_rr.sv
// Round-robin arbiter for the 4-master shared bus: one-hot registered grant,
// tenure bounded by a hold cap and a slave-ready timeout that flags bus_err.
module bus_arbiter_rr #(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned TIMEOUT  = 64
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [3:0] mreq,
    input  logic       s_rdy,
    output logic [3:0] grnt,
    output logic [1:0] owner,
    output logic       bus_err
);

    localparam int unsigned CW = 8;
    localparam logic [CW-1:0] HOLD_LIM = CW'(MAX_HOLD);
    localparam logic [CW-1:0] TMO_LIM  = CW'(TIMEOUT);
    localparam logic [CW-1:0] CNT_MAX  = '1;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   hold_cnt_q;
    logic [CW-1:0]   wait_cnt_q;
    logic [1:0]      last_q;

    logic [CW-1:0]   hold_cnt_d;
    logic [CW-1:0]   wait_cnt_d;
    logic [1:0]      winner;
    logic [1:0]      idx;
    logic            win_valid;
    logic            rel_drop;
    logic            rel_tmo;
    logic            rel_cap;

    // Search upward from the master after the last one granted, wrapping 3->0.
    always_comb begin
        win_valid = 1'b0;
        winner    = 2'd0;
        idx       = 2'd0;
        for (int i = 1; i <= 4; i++) begin
            idx = last_q + 2'(i);
            if (!win_valid && mreq[idx]) begin
                win_valid = 1'b1;
                winner    = idx;
            end
        end
    end

    always_comb begin
        hold_cnt_d = (hold_cnt_q == CNT_MAX) ? hold_cnt_q : hold_cnt_q + CW'(1);
        wait_cnt_d = s_rdy ? '0 :
                     ((wait_cnt_q == CNT_MAX) ? wait_cnt_q : wait_cnt_q + CW'(1));
        rel_drop   = ~mreq[owner];
        rel_tmo    = ~s_rdy && (wait_cnt_q == TMO_LIM);
        rel_cap    = s_rdy && (hold_cnt_q >= HOLD_LIM) && ((mreq & ~grnt) != 4'b0000);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= IDLE;
            grnt       <= 4'b0000;
            owner      <= 2'd0;
            bus_err    <= 1'b0;
            hold_cnt_q <= '0;
            wait_cnt_q <= '0;
            last_q     <= 2'd3;
        end else begin
            bus_err <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (win_valid) begin
                        grnt       <= 4'b0001 << winner;
                        owner      <= winner;
                        last_q     <= winner;
                        hold_cnt_q <= CW'(1);
                        wait_cnt_q <= s_rdy ? '0 : CW'(1);
                        state_q    <= OWN;
                    end
                end
                OWN: begin
                    // A voluntary drop masks a coincident timeout, so no error then.
                    if (rel_drop || rel_tmo || rel_cap) begin
                        grnt    <= 4'b0000;
                        state_q <= IDLE;
                        bus_err <= ~rel_drop & rel_tmo;
                    end else begin
                        hold_cnt_q <= hold_cnt_d;
                        wait_cnt_q <= wait_cnt_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/bus_arbiter_rr.md
Name: bus_arbiter_rr

Overview:
Round-robin arbiter for the shared 4-master / 8-slave system bus.
- Takes the four master request lines and the selected slave's ready, and drives the one-hot grant consumed by the bus mux.
- Bounds bus tenure with a hold cap.
- Recovers from a stalled slave with a ready timeout that raises a bus error.

Parameters:
- MAX_HOLD, 16, max owned cycles while others wait; legal 1..255.
- TIMEOUT, 64, max consecutive owned cycles with s_rdy low before forced release; legal 1..255.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- mreq  in  4  per-master bus request, bit i = master i.
- s_rdy  in  1  ready/ack from the currently selected slave.
- grnt  out  4  one-hot grant, registered; 0 = bus idle.
- owner  out  2  index of the granted master; valid when grnt != 0.
- bus_err  out  1  one-cycle pulse on timeout release.

Behaviour:
- Reset (async, immediate): grnt=0, owner=0, bus_err=0, state=IDLE, hold_cnt=0, wait_cnt=0, last=3. Because last=3, master 0 has first priority.
- All outputs are registered. Counters are 8 bits.
- States: IDLE, OWN.
- IDLE:
  - grnt=0.
  - If mreq!=0, the winner is the first set bit searching (last+1) mod 4 upward, wrapping 3->0.
  - Next edge: grnt=1<<winner, owner=winner, last=winner, hold_cnt=1, wait_cnt = s_rdy ? 0 : 1, state=OWN.
  - Latency from mreq rise to grnt = 1 clock.
  - If mreq==0, stay in IDLE.
- OWN, each edge:
  - hold_cnt saturates at 255.
  - wait_cnt = s_rdy ? 0 : wait_cnt+1.
  - Release conditions, evaluated in priority order:
    - (a) mreq[owner]==0: release, no error.
    - (b) s_rdy==0 and wait_cnt==TIMEOUT: release, bus_err=1 on the next cycle.
    - (c) s_rdy==1, hold_cnt>=MAX_HOLD, and (mreq & ~grnt)!=0: release.
    - Otherwise increment hold_cnt and stay in OWN.
- Release:
  - Next edge: grnt=0, state=IDLE.
  - Exactly one idle cycle always separates two tenures, including re-grant to the same master.
  - bus_err is high only during that idle cycle.
- Round-robin fairness: last is updated only on grant. The releasing master therefore has lowest priority at the next arbitration.
- With no competitors, the hold cap never fires; the owner keeps the bus as long as mreq[owner]=1 and the slave is not stalled.
- Simultaneous events:
  - (a) together with (b): no bus_err.
  - (b) together with (c) cannot occur, since they require opposite s_rdy values.
  - New requests arriving during OWN are only sampled at the next IDLE.
- Reset mid-tenure: grnt drops asynchronously; arbitration restarts from master 0.
- owner holds its last value while grnt=0.

Test Plan:
1. Reset, then mreq=4'b0100 held, s_rdy=1 → grnt=4'b0100 and owner=2 exactly one clock after mreq. Drop mreq → grnt=0 one clock later, bus_err stays 0.
2. MAX_HOLD=4, mreq=4'b1111 constant, s_rdy=1 → grant sequence 0001,0010,0100,1000,0001. Each grant lasts 4 cycles, followed by 1 cycle of grnt=0.
3. MAX_HOLD=4, only mreq[1] set, held 20 cycles → grnt=4'b0010 for 20 cycles without interruption. grnt=0 one clock after mreq falls.
4. TIMEOUT=8, mreq=4'b0001, s_rdy=0 → grnt=0001 for 8 cycles, then grnt=0 with bus_err=1 for exactly 1 cycle. Re-grant to master 0 follows in the next cycle.
5. TIMEOUT=8, s_rdy=0, mreq[0] dropped on the same cycle the timeout is reached → release with bus_err=0.
6. Reset asserted mid-tenure with owner=3 and mreq=4'b1111 → grnt=0 immediately, without waiting for a clock edge. After reset deasserts, the first grant goes to master 0 one clock later.
